// File: rtl/getir_pkg.sv
// Shared definitions for the fetch sequencer: FSM encoding, reset PS default,
// NOP encoding and an address alignment helper.
package getir_pkg;

    typedef enum logic [1:0] {
        ISTE  = 2'd0,   // no request outstanding
        BEKLE = 2'd1,   // one request outstanding
        IPTAL = 2'd2    // one request outstanding, its response is discarded
    } durum_e;

    localparam logic [31:0] RESET_PS_VARSAYILAN = 32'h0000_0000;
    localparam logic [31:0] NOP                 = 32'h0000_0013;

    // Word-aligned memory address for a (possibly halfword aligned) PS.
    function automatic logic [31:0] hizala(input logic [31:0] ps);
        return {ps[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/getir_fifo.sv
// DERINLIK-entry FIFO of {ps, word} pairs with push, pop, flush and occupancy count.
// DERINLIK must be a power of two so the pointers wrap naturally.
module getir_fifo #(
    parameter int DERINLIK = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  logic [63:0]                   veri_i,
    input  logic                          pop_i,
    input  logic                          flush_i,
    output logic [63:0]                   bas_o,
    output logic [$clog2(DERINLIK+1)-1:0] sayi_o
);

    localparam int PW = $clog2(DERINLIK);
    localparam int CW = $clog2(DERINLIK+1);

    logic [PW-1:0] yaz_q, yaz_d, oku_q, oku_d;
    logic [CW-1:0] sayi_q, sayi_d;
    logic [63:0]   mem_q [DERINLIK];

    // Pointer and count update; flush empties the buffer and wins over push/pop.
    always_comb begin
        yaz_d  = yaz_q;
        oku_d  = oku_q;
        sayi_d = sayi_q;
        if (flush_i) begin
            yaz_d  = '0;
            oku_d  = '0;
            sayi_d = '0;
        end else begin
            if (push_i) yaz_d = yaz_q + PW'(1);
            if (pop_i)  oku_d = oku_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   sayi_d = sayi_q + CW'(1);
                2'b01:   sayi_d = sayi_q - CW'(1);
                default: sayi_d = sayi_q;
            endcase
        end
    end

    // Pointer/count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            yaz_q  <= '0;
            oku_q  <= '0;
            sayi_q <= '0;
        end else begin
            yaz_q  <= yaz_d;
            oku_q  <= oku_d;
            sayi_q <= sayi_d;
        end
    end

    // Storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DERINLIK; i++) mem_q[i] <= '0;
        end else if (push_i && !flush_i) begin
            mem_q[yaz_q] <= veri_i;
        end
    end

    assign bas_o  = mem_q[oku_q];
    assign sayi_o = sayi_q;

endmodule

// File: rtl/getir_denetleyici.sv
// Fetch sequencer: issues word-aligned fetches, buffers {ps, word} responses,
// feeds the instruction queue and handles branch redirects.
// Optional GETIR_SAYAC_EN adds pushed/dropped/empty-cycle counters.
module getir_denetleyici
    import getir_pkg::*;
#(
    parameter logic [31:0] RESET_PS = RESET_PS_VARSAYILAN,
    parameter int          DERINLIK = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dallanma_gecerli_i,
    input  logic [31:0] dallanma_ps_i,
    input  logic        cekirdek_durdur_i,
    output logic        obellek_istek_o,
    output logic [31:0] obellek_adres_o,
    input  logic        obellek_hazir_i,
    input  logic        obellek_veri_gecerli_i,
    input  logic [31:0] obellek_veri_i,
    output logic        kuyruk_aktif_o,
    output logic        ps_atladi_o,
    output logic [31:0] ps_o,
    output logic [31:0] buyruk_o,
    input  logic        ps_durdur_i,
    input  logic        ps_iki_artir_i
`ifdef GETIR_SAYAC_EN
    ,
    output logic [31:0] sayac_getirilen_o,
    output logic [31:0] sayac_iptal_o,
    output logic [31:0] sayac_bos_o
`endif
);

    localparam int CW = $clog2(DERINLIK+1);

    durum_e        durum_q, durum_d;
    logic [31:0]   getir_ps_q, getir_ps_d;
    logic [31:0]   istek_ps_q, istek_ps_d;
    logic [63:0]   bas;
    logic [CW-1:0] sayi;
    logic          bos, kabul, push, pop, dusur;

    // ps_iki_artir_i only tells the queue's own PS bookkeeping what happened;
    // the word is consumed either way, so it does not change the pop.
    assign bos   = (sayi == '0);
    assign kabul = obellek_istek_o & obellek_hazir_i;
    assign push  = (durum_q == BEKLE) & obellek_veri_gecerli_i & !dallanma_gecerli_i;
    assign dusur = obellek_veri_gecerli_i &
                   ((durum_q == IPTAL) | ((durum_q == BEKLE) & dallanma_gecerli_i));
    assign pop   = kuyruk_aktif_o & !ps_durdur_i;

    // Memory and queue side outputs; forced to zero while reset is held.
    always_comb begin
        obellek_istek_o = !rst_i && (durum_q == ISTE) && (sayi < CW'(DERINLIK)) &&
                          !dallanma_gecerli_i;
        obellek_adres_o = obellek_istek_o ? hizala(getir_ps_q) : '0;
        kuyruk_aktif_o  = !rst_i && !bos && !cekirdek_durdur_i && !dallanma_gecerli_i;
        ps_atladi_o     = !rst_i && dallanma_gecerli_i;
        buyruk_o        = bos ? '0 : bas[31:0];
        if (rst_i)                   ps_o = '0;
        else if (dallanma_gecerli_i) ps_o = dallanma_ps_i;
        else                         ps_o = bos ? '0 : bas[63:32];
    end

    // Next-state: at most one outstanding request; a redirect redirects the
    // fetch PS and marks any in-flight response as stale.
    always_comb begin
        durum_d    = durum_q;
        getir_ps_d = getir_ps_q;
        istek_ps_d = istek_ps_q;
        case (durum_q)
            ISTE: if (kabul) begin
                durum_d    = BEKLE;
                getir_ps_d = getir_ps_q + 32'd4;
                istek_ps_d = hizala(getir_ps_q);
            end
            BEKLE: begin
                if (obellek_veri_gecerli_i) durum_d = ISTE;
                else if (dallanma_gecerli_i) durum_d = IPTAL;
            end
            IPTAL: if (obellek_veri_gecerli_i) durum_d = ISTE;
            default: durum_d = ISTE;
        endcase
        if (dallanma_gecerli_i) getir_ps_d = dallanma_ps_i;
    end

    // FSM and fetch PS registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q    <= ISTE;
            getir_ps_q <= RESET_PS;
            istek_ps_q <= '0;
        end else begin
            durum_q    <= durum_d;
            getir_ps_q <= getir_ps_d;
            istek_ps_q <= istek_ps_d;
        end
    end

    getir_fifo #(.DERINLIK(DERINLIK)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .veri_i  ({istek_ps_q, obellek_veri_i}),
        .pop_i   (pop),
        .flush_i (dallanma_gecerli_i),
        .bas_o   (bas),
        .sayi_o  (sayi)
    );

`ifdef GETIR_SAYAC_EN
    logic [31:0] getirilen_q, getirilen_d, iptal_q, iptal_d, bos_q, bos_d;

    // Event counters, free-running and wrapping.
    always_comb begin
        getirilen_d = getirilen_q + (push ? 32'd1 : 32'd0);
        iptal_d     = iptal_q + (dusur ? 32'd1 : 32'd0);
        bos_d       = bos_q + ((bos && !cekirdek_durdur_i) ? 32'd1 : 32'd0);
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            getirilen_q <= '0;
            iptal_q     <= '0;
            bos_q       <= '0;
        end else begin
            getirilen_q <= getirilen_d;
            iptal_q     <= iptal_d;
            bos_q       <= bos_d;
        end
    end

    assign sayac_getirilen_o = getirilen_q;
    assign sayac_iptal_o     = iptal_q;
    assign sayac_bos_o       = bos_q;
`else
    logic dusur_kullanilmadi;
    assign dusur_kullanilmadi = dusur & ps_iki_artir_i;
`endif

endmodule
